divider_frontend: RTL

- Request/response wrapper placed directly upstream of the 16-bit reciprocal-multiply divider core.
- Accepts operand pairs over a valid/ready handshake and drives the core's a/b inputs.
- Tracks the core's fixed latency with a tag pipeline, patches the special cases a==0 and b==0, and buffers results in a small FIFO so downstream logic can apply backpressure. The core itself cannot stall.

---
 rtl/divider_frontend.sv | 138 +++++++++++++
 1 files changed

// File: rtl/divider_frontend.sv
// Request/response wrapper for the fixed-latency reciprocal divider core.
// Tags in-flight requests, patches a==0 / b==0 and buffers results in a FIFO.
module divider_frontend #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             out_dz,
  output logic             idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0]      occ_q, occ_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [LATENCY-1:0] tv_q, tv_d;
  logic [LATENCY-1:0] taz_q, taz_d;
  logic [LATENCY-1:0] tbz_q, tbz_d;
  logic [WIDTH:0]     mem_q [DEPTH];
  logic [WIDTH:0]     mem_d [DEPTH];
  logic [WIDTH:0]     head_q, head_d;
  logic [WIDTH:0]     cap_e;
  logic               issue;
  logic               pop;
  logic               cap;

  assign div_a     = in_a;
  assign div_b     = in_b;
  assign in_ready  = !reset && (occ_q < FULL);
  assign issue     = in_valid && in_ready;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign cap       = tv_q[LATENCY-1];
  assign out_q     = head_q[WIDTH-1:0];
  assign out_dz    = head_q[WIDTH];
  assign idle      = (occ_q == '0);

  // Credit counter: FIFO entries plus requests still inside the core.
  always_comb begin
    occ_d = occ_q;
    unique case ({issue, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Tag pipeline shadowing the core: {valid, a==0, b==0} per stage.
  always_comb begin
    tv_d     = '0;
    taz_d    = '0;
    tbz_d    = '0;
    tv_d[0]  = issue;
    taz_d[0] = issue && (in_a == '0);
    tbz_d[0] = issue && (in_b == '0);
    for (int i = 1; i < LATENCY; i++) begin
      tv_d[i]  = tv_q[i-1];
      taz_d[i] = taz_q[i-1];
      tbz_d[i] = tbz_q[i-1];
    end
  end

  // Patch special cases; b==0 wins over a==0.
  always_comb begin
    cap_e = {1'b0, div_r};
    if (tbz_q[LATENCY-1]) begin
      cap_e = {1'b1, {WIDTH{1'b1}}};
    end else if (taz_q[LATENCY-1]) begin
      cap_e = '0;
    end
  end

  // FIFO next state; head register reads the post-write storage.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (cap) begin
      mem_d[wptr_q] = cap_e;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({cap, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    head_d = mem_d[rptr_d];
  end

  // State registers; reset drops in-flight tags and all FIFO contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= '0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      tv_q   <= '0;
      taz_q  <= '0;
      tbz_q  <= '0;
      head_q <= '0;
    end else begin
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      tv_q   <= tv_d;
      taz_q  <= taz_d;
      tbz_q  <= tbz_d;
      head_q <= head_d;
    end
  end

  // Result storage needs no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
